// File: rtl/ball_pkg.sv
// Shared constants and types for the bouncing-ball position engine and renderer.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    localparam int SCREEN_W     = 1024;
    localparam int SCREEN_H     = 768;
    localparam int BALL_RADIUS  = 16;
    localparam int BALL_X_SPEED = 2;
    localparam int BALL_Y_SPEED = 2;

    // Ceiling log2, used to size position ports from screen dimensions.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: next position and direction with wall reflection.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int dim    = SCREEN_W,
    parameter int radius = BALL_RADIUS,
    parameter int speed  = BALL_X_SPEED
) (
    input  logic [log2(dim)-1:0] pos,
    input  logic                 dir,
    output logic [log2(dim)-1:0] nxt_pos,
    output logic                 nxt_dir,
    output logic                 hit
);

    localparam int PW = log2(dim);
    localparam int EW = PW + 1;

    // One extra bit so pos+speed cannot wrap before the bound compare.
    localparam logic [EW-1:0] LO     = EW'(radius);
    localparam logic [EW-1:0] HI     = EW'(dim - 1 - radius);
    localparam logic [EW-1:0] SPD    = EW'(speed);
    localparam logic [EW-1:0] LO_SPD = EW'(radius + speed);

    logic [EW-1:0] pos_x;
    logic [EW-1:0] sum_x;

    assign pos_x = {1'b0, pos};
    assign sum_x = pos_x + SPD;

    always_comb begin
        nxt_pos = pos;
        nxt_dir = dir;
        hit     = 1'b0;
        if (dir == DIR_POS) begin
            if (sum_x > HI) begin
                nxt_pos = HI[PW-1:0];
                nxt_dir = DIR_NEG;
                hit     = 1'b1;
            end else begin
                nxt_pos = sum_x[PW-1:0];
            end
        end else begin
            if (pos_x < LO_SPD) begin
                nxt_pos = LO[PW-1:0];
                nxt_dir = DIR_POS;
                hit     = 1'b1;
            end else begin
                nxt_pos = pos - SPD[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball centre position engine: steps once per frame_div frame_start pulses.
// Optional BALL_BOUNCE_CNT_EN adds a saturating 16-bit bounce_cnt output.
module ball_motion
    import ball_pkg::*;
#(
    parameter int width       = SCREEN_W,
    parameter int height      = SCREEN_H,
    parameter int ball_radius = BALL_RADIUS,
    parameter int x_speed     = BALL_X_SPEED,
    parameter int y_speed     = BALL_Y_SPEED,
    parameter int start_x     = 512,
    parameter int start_y     = 384,
    parameter int frame_div   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    run,
    input  logic                    frame_start,
    output logic [log2(width)-1:0]  h_pos,
    output logic [log2(height)-1:0] v_pos,
    output logic                    x_dir,
    output logic                    y_dir,
    output logic                    ball_en,
    output logic                    move,
    output logic                    bounce,
`ifdef BALL_BOUNCE_CNT_EN
    output logic [15:0]             bounce_cnt,
`endif
    output state_t                  dbg_state
);

    localparam int XW = log2(width);
    localparam int YW = log2(height);
    localparam logic [7:0] DIV_LAST = 8'(frame_div - 1);

    state_t          state_q;
    logic [7:0]      div_q, div_d;
    logic            pend_q;
    logic [XW-1:0]   h_q, x_nxt;
    logic [YW-1:0]   v_q, y_nxt;
    logic            xd_q, yd_q, x_nxt_dir, y_nxt_dir, x_hit, y_hit;
    logic            ben_q, move_q, bounce_q;
    logic            counted, fire;
`ifdef BALL_BOUNCE_CNT_EN
    logic [15:0]     cnt_q;
`endif

    ball_axis_step #(.dim(width), .radius(ball_radius), .speed(x_speed)) u_axis_x (
        .pos     (h_q),
        .dir     (xd_q),
        .nxt_pos (x_nxt),
        .nxt_dir (x_nxt_dir),
        .hit     (x_hit)
    );

    ball_axis_step #(.dim(height), .radius(ball_radius), .speed(y_speed)) u_axis_y (
        .pos     (v_q),
        .dir     (yd_q),
        .nxt_pos (y_nxt),
        .nxt_dir (y_nxt_dir),
        .hit     (y_hit)
    );

    // Pulses are counted in STEP too; one that completes the divider there is parked in pend_q.
    always_comb begin
        counted = frame_start && run && ((state_q == RUN) || (state_q == STEP));
        fire    = counted && (div_q == DIV_LAST);
        div_d   = div_q;
        if (fire) begin
            div_d = 8'd0;
        end else if (counted) begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= 8'd0;
            pend_q   <= 1'b0;
            h_q      <= XW'(start_x);
            v_q      <= YW'(start_y);
            xd_q     <= DIR_POS;
            yd_q     <= DIR_POS;
            ben_q    <= 1'b0;
            move_q   <= 1'b0;
            bounce_q <= 1'b0;
`ifdef BALL_BOUNCE_CNT_EN
            cnt_q    <= 16'd0;
`endif
        end else begin
            move_q   <= 1'b0;
            bounce_q <= 1'b0;
            ben_q    <= enable;
            if (!enable) begin
                state_q <= IDLE;
                div_q   <= 8'd0;
                pend_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= RUN;
                    RUN: begin
                        if (!run) begin
                            state_q <= PAUSE;
                        end else begin
                            div_q <= div_d;
                            if (pend_q || fire) begin
                                state_q <= STEP;
                                pend_q  <= pend_q && fire;
                            end
                        end
                    end
                    PAUSE: if (run) state_q <= RUN;
                    STEP: begin
                        h_q      <= x_nxt;
                        v_q      <= y_nxt;
                        xd_q     <= x_nxt_dir;
                        yd_q     <= y_nxt_dir;
                        move_q   <= 1'b1;
                        bounce_q <= x_hit | y_hit;
`ifdef BALL_BOUNCE_CNT_EN
                        if ((x_hit | y_hit) && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
`endif
                        div_q    <= div_d;
                        pend_q   <= pend_q | fire;
                        state_q  <= RUN;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign h_pos     = h_q;
    assign v_pos     = v_q;
    assign x_dir     = xd_q;
    assign y_dir     = yd_q;
    assign ball_en   = ben_q;
    assign move      = move_q;
    assign bounce    = bounce_q;
    assign dbg_state = state_q;
`ifdef BALL_BOUNCE_CNT_EN
    assign bounce_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: two instances (default centre, near bottom-right corner with frame_div=4).
module tb_ball_motion;
  import ball_pkg::*;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int EW = XW + YW + 3;

  logic clk, reset, enable, run, frame_start;
  logic [XW-1:0] h_a, h_b;
  logic [YW-1:0] v_a, v_b;
  logic xd_a, yd_a, ben_a, move_a, bounce_a;
  logic xd_b, yd_b, ben_b, move_b, bounce_b;
  state_t st_a, st_b;
`ifdef BALL_BOUNCE_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  ball_motion dut_a (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frame_start(frame_start),
    .h_pos(h_a), .v_pos(v_a), .x_dir(xd_a), .y_dir(yd_a), .ball_en(ben_a),
    .move(move_a), .bounce(bounce_a),
`ifdef BALL_BOUNCE_CNT_EN
    .bounce_cnt(cnt_a),
`endif
    .dbg_state(st_a)
  );

  ball_motion #(.start_x(1005), .start_y(749), .frame_div(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frame_start(frame_start),
    .h_pos(h_b), .v_pos(v_b), .x_dir(xd_b), .y_dir(yd_b), .ball_en(ben_b),
    .move(move_b), .bounce(bounce_b),
`ifdef BALL_BOUNCE_CNT_EN
    .bounce_cnt(cnt_b),
`endif
    .dbg_state(st_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model + scoreboard
  logic [EW-1:0] exp_a[$];
  logic [EW-1:0] exp_b[$];
  int mh[2], mv[2], mxd[2], myd[2], mdiv[2], mbn[2];
  int fdiv[2] = '{1, 4};

  task automatic axis_model(input int pos, input int dir, input int dim, input int spd,
                            output int np, output int nd, output int hit);
    int lo, hi;
    lo = 16;
    hi = dim - 1 - 16;
    np = pos; nd = dir; hit = 0;
    if (dir == 1) begin
      if (pos + spd > hi) begin np = hi; nd = 0; hit = 1; end
      else np = pos + spd;
    end else begin
      if (pos - spd < lo) begin np = lo; nd = 1; hit = 1; end
      else np = pos - spd;
    end
  endtask

  task automatic model_reset();
    mh = '{512, 1005};
    mv = '{384, 749};
    mxd = '{1, 1};
    myd = '{1, 1};
    mdiv = '{0, 0};
    mbn = '{0, 0};
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic model_count();
    int nh, nxd, hx, nv, nyd, hy, b;
    logic [EW-1:0] e;
    for (int i = 0; i < 2; i++) begin
      mdiv[i]++;
      if (mdiv[i] == fdiv[i]) begin
        mdiv[i] = 0;
        axis_model(mh[i], mxd[i], 1024, 2, nh, nxd, hx);
        axis_model(mv[i], myd[i], 768, 2, nv, nyd, hy);
        mh[i] = nh; mv[i] = nv; mxd[i] = nxd; myd[i] = nyd;
        b = (hx != 0 || hy != 0) ? 1 : 0;
        mbn[i] += b;
        e = {mh[i][XW-1:0], mv[i][YW-1:0], mxd[i][0], myd[i][0], b[0]};
        if (i == 0) exp_a.push_back(e);
        else exp_b.push_back(e);
      end
    end
  endtask

  // driver tasks
  task automatic pulse(input logic counted);
    @(posedge clk); #1 frame_start = 1'b1;
    if (counted) model_count();
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // monitor: every step compared against the queue, outputs otherwise held
  logic [EW-1:0] obs_a, obs_b, prev_a, prev_b;
  logic pmv_a, pmv_b;
  logic prev_ok = 1'b0;
  assign obs_a = {h_a, v_a, xd_a, yd_a, bounce_a};
  assign obs_b = {h_b, v_b, xd_b, yd_b, bounce_b};

  task automatic mon(input int idx, input logic [EW-1:0] obs, input logic mv_now,
                     input logic [EW-1:0] prev, input logic prev_mv);
    logic [EW-1:0] e;
    int qs;
    if (!mv_now) begin
      chk(idx == 0 ? "hold_a" : "hold_b", 32'(obs), 32'({prev[EW-1:1], 1'b0}));
    end else begin
      chk(idx == 0 ? "move_width_a" : "move_width_b", 32'(prev_mv), 32'd0);
      qs = (idx == 0) ? exp_a.size() : exp_b.size();
      checks++;
      assert (qs > 0) else begin
        errors++;
        $error("FAIL move_unexpected_%0d observed=move expected=no_move", idx);
      end
      if (qs > 0) begin
        if (idx == 0) e = exp_a.pop_front();
        else e = exp_b.pop_front();
        chk(idx == 0 ? "step_a" : "step_b", 32'(obs), 32'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok) begin
        mon(0, obs_a, move_a, prev_a, pmv_a);
        mon(1, obs_b, move_b, prev_b, pmv_b);
      end
      prev_a = obs_a; prev_b = obs_b;
      pmv_a = move_a; pmv_b = move_b;
      prev_ok = 1'b1;
    end
  end

  // directed sequence
  initial begin
    reset = 1'b0; enable = 1'b0; run = 1'b0; frame_start = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_h_a", 32'(h_a), 32'd512);
    chk("rst_v_a", 32'(v_a), 32'd384);
    chk("rst_xd_a", 32'(xd_a), 32'd1);
    chk("rst_yd_a", 32'(yd_a), 32'd1);
    chk("rst_ben_a", 32'(ben_a), 32'd0);
    chk("rst_move_a", 32'(move_a), 32'd0);
    chk("rst_bounce_a", 32'(bounce_a), 32'd0);
    chk("rst_state_a", 32'(st_a), 32'(IDLE));
    chk("rst_h_b", 32'(h_b), 32'd1005);
    chk("rst_v_b", 32'(v_b), 32'd749);
`ifdef BALL_BOUNCE_CNT_EN
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
`endif
    wait_cycles(2);
    #1 reset = 1'b0;

    // frame_start ignored in IDLE
    pulse(1'b0);
    wait_cycles(3);
    #1 chk("idle_h_a", 32'(h_a), 32'd512);
    chk("idle_state_a", 32'(st_a), 32'(IDLE));

    enable = 1'b1; run = 1'b1;
    @(posedge clk); #1;
    chk("run_state_a", 32'(st_a), 32'(RUN));
    chk("run_ben_a", 32'(ben_a), 32'd1);

    // steady step with exact latency
    @(posedge clk); #1 frame_start = 1'b1;
    model_count();
    @(posedge clk); #1 frame_start = 1'b0;
    chk("lat_state_a", 32'(st_a), 32'(STEP));
    chk("lat_h_hold_a", 32'(h_a), 32'd512);
    @(posedge clk); #1;
    chk("step1_h_a", 32'(h_a), 32'd514);
    chk("step1_v_a", 32'(v_a), 32'd386);
    chk("step1_move_a", 32'(move_a), 32'd1);
    chk("step1_bounce_a", 32'(bounce_a), 32'd0);
    @(posedge clk); #1;
    chk("step1_move_low_a", 32'(move_a), 32'd0);

    // dut_b: 1005 -> 1007 (no hit), then corner clamp with both dirs flipped
    for (int i = 0; i < 3; i++) begin pulse(1'b1); wait_cycles(3); end
    #1 chk("wall1_h_b", 32'(h_b), 32'd1007);
    chk("wall1_xd_b", 32'(xd_b), 32'd1);
    for (int i = 0; i < 3; i++) begin pulse(1'b1); wait_cycles(3); end
    pulse(1'b1);
    @(posedge clk); #1;
    chk("corner_h_b", 32'(h_b), 32'd1007);
    chk("corner_v_b", 32'(v_b), 32'd751);
    chk("corner_xd_b", 32'(xd_b), 32'd0);
    chk("corner_yd_b", 32'(yd_b), 32'd0);
    chk("corner_bounce_b", 32'(bounce_b), 32'd1);
    @(posedge clk); #1;
    chk("corner_bounce_low_b", 32'(bounce_b), 32'd0);
    for (int i = 0; i < 4; i++) begin pulse(1'b1); wait_cycles(3); end
    #1 chk("after_corner_h_b", 32'(h_b), 32'd1005);

    // run low for 3 frames in the middle of a divide-by-4 count
    for (int i = 0; i < 2; i++) begin pulse(1'b1); wait_cycles(3); end
    run = 1'b0;
    @(posedge clk); #1 chk("pause_state_a", 32'(st_a), 32'(PAUSE));
    for (int i = 0; i < 3; i++) begin pulse(1'b0); wait_cycles(3); end
    #1 chk("pause_h_a", 32'(h_a), 32'(mh[0]));
    chk("pause_h_b", 32'(h_b), 32'(mh[1]));
    run = 1'b1;
    @(posedge clk); #1 chk("resume_state_a", 32'(st_a), 32'(RUN));
    for (int i = 0; i < 2; i++) begin pulse(1'b1); wait_cycles(3); end
    #1 chk("resume_h_b", 32'(h_b), 32'(mh[1]));

    // frame_start held into the STEP cycle is still counted
    @(posedge clk); #1 frame_start = 1'b1;
    model_count();
    @(posedge clk); #1 model_count();
    @(posedge clk); #1 frame_start = 1'b0;
    wait_cycles(6);
    #1 chk("back2back_h_a", 32'(h_a), 32'(mh[0]));
    chk("back2back_v_a", 32'(v_a), 32'(mv[0]));

    // disable/re-enable keeps the position
    while (mdiv[1] != 0) begin pulse(1'b1); wait_cycles(3); end
    enable = 1'b0;
    @(posedge clk); #1;
    chk("dis_state_a", 32'(st_a), 32'(IDLE));
    chk("dis_ben_a", 32'(ben_a), 32'd0);
    for (int i = 0; i < 2; i++) begin pulse(1'b0); wait_cycles(2); end
    #1 chk("dis_h_a", 32'(h_a), 32'(mh[0]));
    enable = 1'b1;
    wait_cycles(2);

    // long run into walls with random spacing
    for (int i = 0; i < 260; i++) begin
      pulse(1'b1);
      wait_cycles($urandom_range(2, 5));
    end
    wait_cycles(6);
    #1;
    chk("long_h_a", 32'(h_a), 32'(mh[0]));
    chk("long_v_a", 32'(v_a), 32'(mv[0]));
    chk("long_xd_a", 32'(xd_a), 32'(mxd[0]));
    chk("long_yd_a", 32'(yd_a), 32'(myd[0]));
    chk("long_h_b", 32'(h_b), 32'(mh[1]));
    chk("long_v_b", 32'(v_b), 32'(mv[1]));
`ifdef BALL_BOUNCE_CNT_EN
    chk("cnt_a", 32'(cnt_a), 32'(mbn[0]));
    chk("cnt_b", 32'(cnt_b), 32'(mbn[1]));
`endif
    chk("queue_a_empty", 32'(exp_a.size()), 32'd0);
    chk("queue_b_empty", 32'(exp_b.size()), 32'd0);

    // async reset between edges while dut_a is in STEP
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    chk("pre_rst_state_a", 32'(st_a), 32'(STEP));
    #2 reset = 1'b1;
    #1;
    chk("arst_h_a", 32'(h_a), 32'd512);
    chk("arst_v_a", 32'(v_a), 32'd384);
    chk("arst_xd_a", 32'(xd_a), 32'd1);
    chk("arst_yd_a", 32'(yd_a), 32'd1);
    chk("arst_move_a", 32'(move_a), 32'd0);
    chk("arst_ben_a", 32'(ben_a), 32'd0);
    chk("arst_state_a", 32'(st_a), 32'(IDLE));
`ifdef BALL_BOUNCE_CNT_EN
    chk("arst_cnt_a", 32'(cnt_a), 32'd0);
`endif
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    wait_cycles(4);
    #1 chk("final_queue_a", 32'(exp_a.size()), 32'd0);
    chk("final_queue_b", 32'(exp_b.size()), 32'd0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
